// File: rtl/execute_stage_if.sv
// Decode <-> execute link: the control word and register operand flowing down,
// and the writeback / jump redirect flowing back up.
interface execute_stage_if;
  logic       in_valid;
  logic [3:0] im;
  logic       is_imm;
  logic       use_in;
  logic       mem_w;
  logic       s_reg;
  logic       is_jump;
  logic       jnc;
  logic       out_en;
  logic [3:0] out_reg;

  logic [3:0] result;
  logic       in_mem_w;
  logic       in_s_reg;
  logic       jump_taken;
  logic [3:0] jump_target;

  modport master (
    output in_valid, im, is_imm, use_in, mem_w, s_reg, is_jump, jnc, out_en, out_reg,
    input  result, in_mem_w, in_s_reg, jump_taken, jump_target
  );

  modport slave (
    input  in_valid, im, is_imm, use_in, mem_w, s_reg, is_jump, jnc, out_en, out_reg,
    output result, in_mem_w, in_s_reg, jump_taken, jump_target
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage of the 4-bit CPU: operand select, 4-bit add, carry flag, OUT port,
// writeback to decode, jump redirect to fetch and post-jump squash of wrong-path slots.
module execute_stage #(
  parameter int FLUSH_SLOTS = 1
) (
  input  logic             clk,
  input  logic             rst,
  execute_stage_if.slave   dec,
  input  logic [3:0]       in_port,
  output logic             carry,
  output logic [3:0]       out_port
);

  localparam int DATA_W = 4;
  localparam int CNT_W  = 2;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_SLOTS);

  // Zero-extended add so the carry-out lands in the top bit.
  function automatic logic [DATA_W:0] add_wide(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [CNT_W-1:0]  squash_cnt_p1;
  logic [DATA_W-1:0] result_p1;
  logic              wb_p1;
  logic              s_reg_p1;
  logic              carry_p1;
  logic              jump_taken_p1;
  logic [DATA_W-1:0] jump_target_p1;
  logic [DATA_W-1:0] out_port_p1;

  // Stage p0: operand select, add, and classification of the accepted instruction
  logic [DATA_W-1:0] operand_p0;
  logic [DATA_W:0]   sum_p0;
  logic [DATA_W-1:0] out_val_p0;
  logic              vld_p0;
  logic              squash_p0;
  logic              do_jump_p0;
  logic              taken_p0;
  logic              do_out_p0;
  logic              do_wb_p0;

  always_comb begin
    operand_p0 = '0;
    if (!dec.is_imm) operand_p0 = dec.use_in ? in_port : dec.out_reg;
    sum_p0     = add_wide(operand_p0, dec.im);
    out_val_p0 = dec.is_imm ? dec.im : dec.out_reg;

    squash_p0  = dec.in_valid && (squash_cnt_p1 != '0);
    vld_p0     = dec.in_valid && (squash_cnt_p1 == '0);

    // Jump dominates: it suppresses both writeback and the port write.
    do_jump_p0 = vld_p0 && dec.is_jump;
    taken_p0   = do_jump_p0 && (!dec.jnc || !carry_p1);
    do_out_p0  = vld_p0 && !dec.is_jump && dec.out_en;
    do_wb_p0   = vld_p0 && !dec.is_jump && dec.mem_w;
  end

  // Stage p1: architectural state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      squash_cnt_p1  <= '0;
      result_p1      <= '0;
      wb_p1          <= 1'b0;
      s_reg_p1       <= 1'b0;
      carry_p1       <= 1'b0;
      jump_taken_p1  <= 1'b0;
      jump_target_p1 <= '0;
      out_port_p1    <= '0;
    end else begin
      wb_p1         <= do_wb_p0;
      jump_taken_p1 <= taken_p0;

      if (squash_p0) squash_cnt_p1 <= squash_cnt_p1 - CNT_W'(1);
      else if (taken_p0) squash_cnt_p1 <= FLUSH_LOAD;

      if (taken_p0) jump_target_p1 <= dec.im;

      if (do_wb_p0) begin
        result_p1 <= sum_p0[DATA_W-1:0];
        s_reg_p1  <= dec.s_reg;
      end

      if (do_out_p0) out_port_p1 <= out_val_p0;

      // Carry is consumed by JNC above before being overwritten here.
      if (do_jump_p0) carry_p1 <= 1'b0;
      else if (do_wb_p0) carry_p1 <= sum_p0[DATA_W];
      else if (do_out_p0) carry_p1 <= 1'b0;
    end
  end

  assign dec.result      = result_p1;
  assign dec.in_mem_w    = wb_p1;
  assign dec.in_s_reg    = s_reg_p1;
  assign dec.jump_taken  = jump_taken_p1;
  assign dec.jump_target = jump_target_p1;
  assign carry           = carry_p1;
  assign out_port        = out_port_p1;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed program fragments followed by random
// instruction streams, all compared against an instruction-level model.
module tb_execute_stage;

  localparam int FLUSH_SLOTS = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_port;
  logic       carry;
  logic [3:0] out_port;

  execute_stage_if bus ();

  execute_stage #(.FLUSH_SLOTS(FLUSH_SLOTS)) dut (
    .clk      (clk),
    .rst      (rst),
    .dec      (bus.slave),
    .in_port  (in_port),
    .carry    (carry),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Instruction-level model state
  int m_squash;
  int m_carry, m_result, m_wb, m_sreg, m_jt, m_jtgt, m_out;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".result"},      {4'd0, bus.result},      8'(m_result));
    chk({where, ".in_mem_w"},    {7'd0, bus.in_mem_w},    8'(m_wb));
    chk({where, ".in_s_reg"},    {7'd0, bus.in_s_reg},    8'(m_sreg));
    chk({where, ".carry"},       {7'd0, carry},           8'(m_carry));
    chk({where, ".jump_taken"},  {7'd0, bus.jump_taken},  8'(m_jt));
    chk({where, ".jump_target"}, {4'd0, bus.jump_target}, 8'(m_jtgt));
    chk({where, ".out_port"},    {4'd0, out_port},        8'(m_out));
  endtask

  task automatic model_reset();
    m_squash = 0; m_carry = 0; m_result = 0; m_wb = 0;
    m_sreg = 0; m_jt = 0; m_jtgt = 0; m_out = 0;
  endtask

  // Applies one instruction of the ISA to the model using the values on the bus.
  task automatic model_exec();
    int op, s;
    m_wb = 0;
    m_jt = 0;
    if (!bus.in_valid) return;
    if (m_squash > 0) begin
      m_squash--;
      return;
    end
    op = bus.is_imm ? 0 : (bus.use_in ? int'(in_port) : int'(bus.out_reg));
    s  = op + int'(bus.im);
    if (bus.is_jump) begin
      if (!bus.jnc || m_carry == 0) begin
        m_jt = 1;
        m_jtgt = int'(bus.im);
        m_squash = FLUSH_SLOTS;
      end
      m_carry = 0;
    end else begin
      if (bus.out_en) begin
        m_out = bus.is_imm ? int'(bus.im) : int'(bus.out_reg);
        m_carry = 0;
      end
      if (bus.mem_w) begin
        m_result = s % 16;
        m_wb = 1;
        m_sreg = int'(bus.s_reg);
        m_carry = (s > 15) ? 1 : 0;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] im, input logic is_imm,
                       input logic use_in, input logic mem_w, input logic s_reg,
                       input logic is_jump, input logic jnc, input logic out_en,
                       input logic [3:0] oreg, input logic [3:0] inp);
    bus.in_valid = v;      bus.im = im;         bus.is_imm = is_imm;
    bus.use_in = use_in;   bus.mem_w = mem_w;   bus.s_reg = s_reg;
    bus.is_jump = is_jump; bus.jnc = jnc;       bus.out_en = out_en;
    bus.out_reg = oreg;    in_port = inp;
  endtask

  task automatic step(input string where);
    model_exec();
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  task automatic do_reset(input string where);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all(where);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    do_reset("reset");

    // ADD A,7 with A=9 -> 0 with carry
    drive(1, 4'd7, 0, 0, 1, 0, 0, 0, 0, 4'd9, 4'd0);
    step("add");
    chk("add_result_lit", {4'd0, bus.result}, 8'd0);
    chk("add_carry_lit", {7'd0, carry}, 8'd1);

    // JNC 5 sees carry=1: not taken, carry cleared
    drive(1, 4'd5, 1, 0, 0, 0, 1, 1, 0, 4'd0, 4'd0);
    step("jnc1");
    chk("jnc1_taken_lit", {7'd0, bus.jump_taken}, 8'd0);
    // Second JNC 5 is taken
    step("jnc2");
    chk("jnc2_taken_lit", {7'd0, bus.jump_taken}, 8'd1);
    chk("jnc2_target_lit", {4'd0, bus.jump_target}, 8'd5);

    // Slot after the taken JNC is squashed
    drive(1, 4'd6, 1, 0, 1, 0, 0, 0, 0, 4'd0, 4'd0);
    step("jnc2_squash");
    chk("jnc2_squash_wb_lit", {7'd0, bus.in_mem_w}, 8'd0);

    // JMP 3 then MOV B,9 (squashed) and MOV B,4
    drive(1, 4'd3, 1, 0, 1, 0, 1, 0, 0, 4'd0, 4'd0);
    step("jmp3");
    chk("jmp3_wb_lit", {7'd0, bus.in_mem_w}, 8'd0);
    drive(1, 4'd9, 1, 0, 1, 1, 0, 0, 0, 4'd0, 4'd0);
    step("movb9");
    chk("movb9_wb_lit", {7'd0, bus.in_mem_w}, 8'd0);
    drive(1, 4'd4, 1, 0, 1, 1, 0, 0, 0, 4'd0, 4'd0);
    step("movb4");
    chk("movb4_result_lit", {4'd0, bus.result}, 8'd4);
    chk("movb4_sreg_lit", {7'd0, bus.in_s_reg}, 8'd1);

    // IN A with switches=15, im=1 -> wraps to 0 with carry
    drive(1, 4'd1, 0, 1, 1, 0, 0, 0, 0, 4'd2, 4'd15);
    step("in");
    chk("in_result_lit", {4'd0, bus.result}, 8'd0);
    chk("in_carry_lit", {7'd0, carry}, 8'd1);

    // OUT 10
    drive(1, 4'd10, 1, 0, 0, 0, 0, 0, 1, 4'd0, 4'd0);
    step("out");
    chk("out_port_lit", {4'd0, out_port}, 8'd10);
    chk("out_carry_lit", {7'd0, carry}, 8'd0);

    // OUT combined with a writeback: port and register both updated
    drive(1, 4'd12, 0, 0, 1, 1, 0, 0, 1, 4'd7, 4'd0);
    step("out_wb");
    chk("out_wb_port_lit", {4'd0, out_port}, 8'd7);
    chk("out_wb_result_lit", {4'd0, bus.result}, 8'd3);

    // Reset right after a taken JMP clears the pending squash
    drive(1, 4'd8, 1, 0, 0, 0, 1, 0, 0, 4'd0, 4'd0);
    step("jmp8");
    do_reset("reset_mid_flush");
    drive(1, 4'd2, 1, 0, 1, 0, 0, 0, 0, 4'd0, 4'd0);
    step("mova2");
    chk("mova2_result_lit", {4'd0, bus.result}, 8'd2);
    chk("mova2_wb_lit", {7'd0, bus.in_mem_w}, 8'd1);

    // Bubbles between a JMP and the next instruction do not consume the squash
    drive(1, 4'd1, 1, 0, 0, 0, 1, 0, 0, 4'd0, 4'd0);
    step("jmp1");
    drive(0, 4'd5, 1, 0, 1, 0, 0, 0, 0, 4'd0, 4'd0);
    step("gap1");
    step("gap2");
    drive(1, 4'd5, 1, 0, 1, 0, 0, 0, 0, 4'd0, 4'd0);
    step("after_gap");
    chk("after_gap_wb_lit", {7'd0, bus.in_mem_w}, 8'd0);
    drive(1, 4'd11, 1, 0, 1, 1, 0, 0, 0, 4'd0, 4'd0);
    step("after_gap2");
    chk("after_gap2_result_lit", {4'd0, bus.result}, 8'd11);

    // Random instruction streams
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset("rand_reset");
      end else begin
        drive($urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0, 1'($urandom),
              $urandom_range(0, 3) == 0, 4'($urandom), 4'($urandom));
        step("rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 4-bit CPU, directly downstream of the decode stage.
- Consumes decode's control word and register operand each cycle, performs the 4-bit add, and updates the carry flag and output port.
- Returns the writeback (result, in_mem_w, in_s_reg) to decode's register file and issues jump redirects to fetch.
- Owns the pipeline flush after a taken jump.

Parameters:
- FLUSH_SLOTS, 1, number of valid instructions squashed after a taken jump (1..3)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decode control word valid this cycle
- im  in  4  immediate from decode
- is_imm  in  1  1: operand = 0 (result = im); 0: operand = register/port
- use_in  in  1  when is_imm=0: 1 selects in_port, 0 selects out_reg
- mem_w  in  1  instruction writes a register
- s_reg  in  1  destination register, 0=A, 1=B
- is_jump  in  1  jump instruction
- jnc  in  1  with is_jump: 1 = jump only if carry==0, 0 = unconditional
- out_en  in  1  OUT instruction
- out_reg  in  4  register operand value from decode
- in_port  in  4  external input switches
- result  out  4  writeback data
- in_mem_w  out  1  writeback strobe (one cycle)
- in_s_reg  out  1  writeback destination
- carry  out  1  carry flag
- jump_taken  out  1  redirect strobe to fetch (one cycle)
- jump_target  out  4  new PC
- out_port  out  4  external output LEDs

Behaviour:
- Reset (sync, priority over everything): result=0, in_mem_w=0, in_s_reg=0, carry=0, jump_taken=0, jump_target=0, out_port=0, squash counter=0.
- An instruction is accepted when in_valid=1 and the squash counter is 0.
- When in_valid=1 and squash counter>0, the instruction is discarded and the counter decrements by 1.
- When in_valid=0, the counter holds.
- Operand: op = is_imm ? 0 : (use_in ? in_port : out_reg). Sum = {1'b0,op} + {1'b0,im}, 5 bits. result = sum[3:0], wrapping modulo 16.
- Latency: one cycle. All outputs are registered in the same edge as acceptance.
- Arithmetic/MOV/IN (mem_w=1, is_jump=0, out_en=0):
  - result = sum[3:0], in_mem_w=1, in_s_reg=s_reg, carry = sum[4].
- Jump (is_jump=1):
  - Taken when jnc=0, or when jnc=1 and carry (pre-instruction value) == 0.
  - Taken: jump_taken=1, jump_target=im, squash counter loads FLUSH_SLOTS.
  - Not taken: no redirect.
  - Carry cleared to 0 in both cases. No writeback, even if mem_w=1 (jump wins).
- OUT (out_en=1, is_jump=0):
  - out_port = is_imm ? im : out_reg. carry cleared to 0. No writeback.
  - out_en=1 together with mem_w=1: both the port write and the writeback occur; carry = sum[4].
- out_port holds its value until the next accepted OUT or reset.
- in_mem_w and jump_taken are single-cycle pulses: 0 on any cycle without a qualifying accepted instruction. result, in_s_reg and jump_target hold their last values.
- A jump accepted while a squash is pending cannot occur (it would be squashed).
- Reset mid-flush clears the counter; the next valid instruction is accepted.
- Carry is read before update: a JNC directly following an overflowing ADD sees carry=1.

Test Plan:
- Reset then ADD A,7 with out_reg=A=9 (is_imm=0, use_in=0, mem_w=1, s_reg=0, im=7) -> next cycle result=0, in_mem_w=1, in_s_reg=0, carry=1.
- Following that, JNC 5 -> jump_taken=0, carry=0. A second JNC 5 -> jump_taken=1, jump_target=5.
- JMP 3 followed by back-to-back valid MOV B,9 then MOV B,4 (FLUSH_SLOTS=1) -> MOV B,9 squashed (no in_mem_w). MOV B,4 produces result=4, in_s_reg=1.
- IN A with in_port=15, im=1 -> result=0, carry=1. OUT im=10 (is_imm=1) -> out_port=10, carry=0, in_mem_w=0.
- Assert rst in the cycle after a taken JMP, then a valid MOV A,2 -> all outputs zero after reset, then result=2, in_mem_w=1 (no squash).
- in_valid=0 gap between JMP and the next instruction -> counter holds, first valid instruction after the gap is squashed.
